// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: program counter, next-PC selection (jr/j/branch/fall-through)
// and the IF/ID pipeline register feeding the control unit.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        is_bne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jump_register,
  input  logic [31:0] rs_value,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;
  logic [31:0] jr_target_s;
  logic        taken_s;

  // Next-PC selection and IF/ID next-state; redirects only act on a live ID instruction.
  always_comb begin
    pc_plus4_s  = pc_q + 32'd4;
    br_target_s = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    j_target_s  = {pc4_q[31:28], instr_q[25:0], 2'b00};
    jr_target_s = {rs_value[31:2], 2'b00};
    taken_s     = branch & (zero ^ is_bne);

    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    count_d    = count_q;

    if (stall) begin
      misalign_d = 1'b0;
    end else if (valid_q && jump_register) begin
      pc_d       = jr_target_s;
      instr_d    = 32'h0000_0000;
      pc4_d      = 32'h0000_0000;
      valid_d    = 1'b0;
      misalign_d = |rs_value[1:0];
    end else if (valid_q && jump) begin
      pc_d    = j_target_s;
      instr_d = 32'h0000_0000;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (valid_q && taken_s) begin
      pc_d    = br_target_s;
      instr_d = 32'h0000_0000;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4_s;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4_s;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset taking precedence over stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0000;
      pc4_q      <= 32'h0000_0000;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'h0000_0000;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign opcode       = instr_q[31:26];
  assign funct        = instr_q[5:0];
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of per-cycle stimulus with hand-derived
// expected IF-stage state, pushed to a scoreboard queue and checked after each edge.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic        is_bne;
  logic        zero;
  logic        jump;
  logic        jump_register;
  logic [31:0] rs_value;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        misalign_err;
  logic [31:0] fetch_count;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .is_bne(is_bne),
    .zero(zero), .jump(jump), .jump_register(jump_register), .rs_value(rs_value),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .opcode(opcode), .funct(funct), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a few hand-placed control-flow words, address-derived elsewhere.
  function automatic logic [31:0] mw(input logic [31:0] a);
    case (a)
      32'h0000_0200: mw = 32'h1022_FFFE;  // beq imm=-2
      32'h0000_0300: mw = 32'h1422_0003;  // bne imm=+3
      32'h0000_0400: mw = 32'h0800_0040;  // j target26=0x40
      32'h0000_0500: mw = 32'h1064_0010;  // beq imm=+16
      default:       mw = a ^ 32'hDEAD_0000;
    endcase
  endfunction

  always_comb imem_rdata = mw(imem_addr);

  typedef struct {
    string       nm;
    logic        rst_n, stall, br, bne, z, j, jr;
    logic [31:0] rs;
    logic [31:0] e_pc, e_instr, e_pc4, e_cnt;
    logic        e_valid, e_mis;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic v(input string nm, input logic r, s, br, bne, z, j, jr,
                   input logic [31:0] rs, e_pc, e_instr, e_pc4,
                   input logic e_valid, e_mis, input logic [31:0] e_cnt);
    vec_t t;
    t.nm = nm; t.rst_n = r; t.stall = s; t.br = br; t.bne = bne; t.z = z;
    t.j = j; t.jr = jr; t.rs = rs; t.e_pc = e_pc; t.e_instr = e_instr;
    t.e_pc4 = e_pc4; t.e_valid = e_valid; t.e_mis = e_mis; t.e_cnt = e_cnt;
    tbl.push_back(t);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b1; stall = 1'b0; branch = 1'b0; is_bne = 1'b0; zero = 1'b0;
    jump = 1'b0; jump_register = 1'b0; rs_value = 32'h0;

    //  name        rst st br bn z  j  jr rs            pc            instr             pc4           vl ms cnt
    v("reset",      0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h100,      32'h0,            32'h0,        0, 0, 32'd0);
    v("fetch1",     1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h104,      mw(32'h100),      32'h104,      1, 0, 32'd1);
    v("fetch2",     1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h108,      mw(32'h104),      32'h108,      1, 0, 32'd2);
    v("jr200",      1, 0, 0, 0, 0, 0, 1, 32'h200,      32'h200,      32'h0,            32'h0,        0, 0, 32'd2);
    v("ign_inval",  1, 0, 1, 0, 1, 1, 0, 32'h0,        32'h204,      32'h1022_FFFE,    32'h204,      1, 0, 32'd3);
    v("beq_taken",  1, 0, 1, 0, 1, 0, 0, 32'h0,        32'h1FC,      32'h0,            32'h0,        0, 0, 32'd3);
    v("beq_tgt",    1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h200,      mw(32'h1FC),      32'h200,      1, 0, 32'd4);
    v("beq_again",  1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h204,      32'h1022_FFFE,    32'h204,      1, 0, 32'd5);
    v("beq_nt",     1, 0, 1, 0, 0, 0, 0, 32'h0,        32'h208,      mw(32'h204),      32'h208,      1, 0, 32'd6);
    v("jr300",      1, 0, 0, 0, 0, 0, 1, 32'h300,      32'h300,      32'h0,            32'h0,        0, 0, 32'd6);
    v("ld_bne",     1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h304,      32'h1422_0003,    32'h304,      1, 0, 32'd7);
    v("bne_taken",  1, 0, 1, 1, 0, 0, 0, 32'h0,        32'h310,      32'h0,            32'h0,        0, 0, 32'd7);
    v("bne_tgt",    1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h314,      mw(32'h310),      32'h314,      1, 0, 32'd8);
    v("jr300b",     1, 0, 0, 0, 0, 0, 1, 32'h300,      32'h300,      32'h0,            32'h0,        0, 0, 32'd8);
    v("ld_bne2",    1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h304,      32'h1422_0003,    32'h304,      1, 0, 32'd9);
    v("bne_nt",     1, 0, 1, 1, 1, 0, 0, 32'h0,        32'h308,      mw(32'h304),      32'h308,      1, 0, 32'd10);
    v("jr400",      1, 0, 0, 0, 0, 0, 1, 32'h400,      32'h400,      32'h0,            32'h0,        0, 0, 32'd10);
    v("ld_j",       1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h404,      32'h0800_0040,    32'h404,      1, 0, 32'd11);
    v("j_taken",    1, 0, 0, 0, 0, 1, 0, 32'h0,        32'h100,      32'h0,            32'h0,        0, 0, 32'd11);
    v("j_tgt",      1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h104,      mw(32'h100),      32'h104,      1, 0, 32'd12);
    v("jr400b",     1, 0, 0, 0, 0, 0, 1, 32'h400,      32'h400,      32'h0,            32'h0,        0, 0, 32'd12);
    v("ld_j2",      1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h404,      32'h0800_0040,    32'h404,      1, 0, 32'd13);
    v("jr_wins",    1, 0, 0, 0, 0, 1, 1, 32'h3003,     32'h3000,     32'h0,            32'h0,        0, 1, 32'd13);
    v("mis_clear",  1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h3004,     mw(32'h3000),     32'h3004,     1, 0, 32'd14);
    v("jr500",      1, 0, 0, 0, 0, 0, 1, 32'h500,      32'h500,      32'h0,            32'h0,        0, 0, 32'd14);
    v("ld_beq",     1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h504,      32'h1064_0010,    32'h504,      1, 0, 32'd15);
    v("stall_jr",   1, 1, 0, 0, 0, 0, 1, 32'h3003,     32'h504,      32'h1064_0010,    32'h504,      1, 0, 32'd15);
    v("stall_br1",  1, 1, 1, 0, 1, 0, 0, 32'h0,        32'h504,      32'h1064_0010,    32'h504,      1, 0, 32'd15);
    v("stall_br2",  1, 1, 1, 0, 1, 0, 0, 32'h0,        32'h504,      32'h1064_0010,    32'h504,      1, 0, 32'd15);
    v("unstall_br", 1, 0, 1, 0, 1, 0, 0, 32'h0,        32'h544,      32'h0,            32'h0,        0, 0, 32'd15);
    v("br_tgt",     1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h548,      mw(32'h544),      32'h548,      1, 0, 32'd16);
    v("jr_top",     1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,            32'h0,        0, 0, 32'd16);
    v("pc_wrap",    1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        mw(32'hFFFF_FFFC),32'h0,        1, 0, 32'd17);
    v("after_wrap", 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h4,        mw(32'h0),        32'h4,        1, 0, 32'd18);
    v("rst_stall",  0, 1, 1, 0, 1, 1, 1, 32'h3003,     32'h100,      32'h0,            32'h0,        0, 0, 32'd0);
    v("post_rst",   1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h104,      mw(32'h100),      32'h104,      1, 0, 32'd1);

    @(negedge clk);
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; stall = tbl[i].stall; branch = tbl[i].br;
      is_bne = tbl[i].bne; zero = tbl[i].z; jump = tbl[i].j;
      jump_register = tbl[i].jr; rs_value = tbl[i].rs;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cmp({e.nm, ".pc"},        pc,                     e.e_pc);
      cmp({e.nm, ".imem_addr"}, imem_addr,              e.e_pc);
      cmp({e.nm, ".instr"},     if_id_instr,            e.e_instr);
      cmp({e.nm, ".pc4"},       if_id_pc4,              e.e_pc4);
      cmp({e.nm, ".valid"},     {31'd0, if_id_valid},   {31'd0, e.e_valid});
      cmp({e.nm, ".misalign"},  {31'd0, misalign_err},  {31'd0, e.e_mis});
      cmp({e.nm, ".count"},     fetch_count,            e.e_cnt);
      cmp({e.nm, ".opcode"},    {26'd0, opcode},        {26'd0, e.e_instr[31:26]});
      cmp({e.nm, ".funct"},     {26'd0, funct},         {26'd0, e.e_instr[5:0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
